// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: serial-to-parallel loader and parallel-to-serial drainer
// wrapped around an external combinational N-lane sorter. Samples arrive one
// per valid/ready beat, are presented in parallel on sort_in, and the sorter's
// result is captured once and replayed lane 0..N-1 with a last-beat flag.
module sort_stream_ctrl #(
  parameter int W = 5,
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [N*W-1:0] sort_in,
  input  logic [N*W-1:0] sort_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           busy
);

  // Counter width; N need not be a power of two, so wrap is explicit at N-1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   lcnt_reg, lcnt_next;
  logic [CW-1:0]   dcnt_reg, dcnt_next;
  logic [N*W-1:0]  obuf_flat;
  logic            in_fire;
  logic            out_fire;

  // Handshakes depend only on registered state plus the partner's strobe.
  assign in_fire  = in_valid  && (state_reg == LOAD);
  assign out_fire = out_ready && (state_reg == DRAIN);

  // Per-lane load and output buffers. Each lane is its own register so the
  // sorter sees all lanes in parallel and the drain mux reads any lane.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [W-1:0] lbuf_reg;
    logic [W-1:0] obuf_reg;

    // Load buffer: written only in LOAD, at the lane addressed by lcnt.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lbuf_reg <= '0;
      end else if (in_fire && (lcnt_reg == CW'(gi))) begin
        lbuf_reg <= in_data;
      end
    end

    // Output buffer: snapshot of the sorter result during the single SORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        obuf_reg <= '0;
      end else if (state_reg == SORT) begin
        obuf_reg <= sort_out[gi*W +: W];
      end
    end

    assign sort_in[gi*W +: W]   = lbuf_reg;
    assign obuf_flat[gi*W +: W] = obuf_reg;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      lcnt_reg  <= '0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lcnt_reg  <= lcnt_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  // Next-state logic and output decode from registered state only.
  always_comb begin
    state_next = state_reg;
    lcnt_next  = lcnt_reg;
    dcnt_next  = dcnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = (state_reg != LOAD);

    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire) begin
          if (lcnt_reg == LAST) begin
            lcnt_next  = '0;
            state_next = SORT;
          end else begin
            lcnt_next = lcnt_reg + CW'(1);
          end
        end
      end

      SORT: begin
        state_next = DRAIN;
      end

      DRAIN: begin
        out_valid = 1'b1;
        out_data  = obuf_flat[dcnt_reg*W +: W];
        out_last  = (dcnt_reg == LAST);
        if (out_fire) begin
          if (dcnt_reg == LAST) begin
            dcnt_next  = '0;
            state_next = LOAD;
          end else begin
            dcnt_next = dcnt_reg + CW'(1);
          end
        end
      end

      default: begin
        state_next = LOAD;
        lcnt_next  = '0;
        dcnt_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Testbench for sort_stream_ctrl: directed frames, a behavioural sorter on
// sort_in/sort_out, and a scoreboard checked by an independent monitor.
module tb_sort_stream_ctrl;
  localparam int W = 5;
  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [N*W-1:0] sort_in;
  logic [N*W-1:0] sort_out;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           busy;

  sort_stream_ctrl #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sort_in(sort_in), .sort_out(sort_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational sorter: ascending order across lanes.
  logic [W-1:0] srt [N];
  logic [W-1:0] tmp;
  always_comb begin
    sort_out = '0;
    tmp = '0;
    for (int i = 0; i < N; i++) srt[i] = sort_in[i*W +: W];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
    for (int i = 0; i < N; i++) sort_out[i*W +: W] = srt[i];
  end

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Push a hand-sorted frame onto the scoreboard, last flag on lane N-1.
  task automatic push_exp(input logic [N*W-1:0] s);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.d = s[i*W +: W];
      e.l = (i == N - 1);
      sb.push_back(e);
    end
  endtask

  // Offer one sample; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] v, input bit gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
    else $display("IN  data=0x%02h", v);
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [N*W-1:0] f, input bit gap);
    for (int i = 0; i < N; i++) send(f[i*W +: W], gap);
  endtask

  // Wait until the block is idle and every expected beat has been seen.
  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = !busy && (sb.size() == 0);
    end
    if (!done) check("idle_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("out_valid_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_sort_in"},   sort_in,   0);
  endtask

  // Monitor: pops the scoreboard on each accepted output beat and checks
  // that a stalled beat holds its data and last flag.
  initial begin
    exp_t         e;
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && prev_stall) begin
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            $display("OUT data=0x%02h last=%0d (exp 0x%02h last=%0d)", out_data, out_last, e.d, e.l);
            check("out_data", out_data, e.d);
            check("out_last", out_last, e.l);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Stimulus.
  initial begin
    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ascending frame with latency and back-to-back output checks.
    out_ready = 1'b1;
    push_exp(pack(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6));
    send_frame(pack(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6), 1'b0);
    @(negedge clk);
    check("f1_sort_in", sort_in, pack(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6));
    check("f1_sort_busy", busy, 1);
    check("f1_sort_out_valid", out_valid, 0);
    check("f1_sort_in_ready", in_ready, 0);
    @(negedge clk);
    check("f1_latency_out_valid", out_valid, 1);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      check("f1_consecutive_valid", out_valid, 1);
    end
    @(negedge clk);
    check("f1_done_in_ready", in_ready, 1);
    check("f1_done_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Reverse frame, then a frame with duplicates.
    push_exp(pack(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6));
    send_frame(pack(5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1), 1'b0);
    wait_idle();
    push_exp(pack(5'd0, 5'd8, 5'd9, 5'd9, 5'd12, 5'd13));
    send_frame(pack(5'd13, 5'd8, 5'd9, 5'd0, 5'd9, 5'd12), 1'b0);
    wait_idle();

    // Back-pressure with in_valid toggling.
    out_ready = 1'b0;
    push_exp(pack(5'h03, 5'h06, 5'h09, 5'h10, 5'h10, 5'h14));
    send_frame(pack(5'h09, 5'h06, 5'h10, 5'h03, 5'h14, 5'h10), 1'b1);
    wait_out_valid();
    check("bp_stall_data", out_data, 5'h03);
    check("bp_stall_in_ready", in_ready, 0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall_data", out_data, 5'h03);
      check("bp_stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!out_valid) break;
      check("bp_drain_in_ready", in_ready, 0);
    end
    check("bp_after_in_ready", in_ready, 1);
    wait_idle();

    // in_valid held with 0x1F through SORT and DRAIN.
    push_exp(pack(5'd1, 5'd2, 5'd3, 5'd10, 5'd20, 5'd30));
    push_exp(pack(5'd0, 5'd2, 5'd4, 5'd7, 5'd11, 5'h1F));
    send_frame(pack(5'd10, 5'd20, 5'd30, 5'd1, 5'd2, 5'd3), 1'b0);
    in_valid = 1'b1;
    in_data  = 5'h1F;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
      check("busy_sort_in_stable", sort_in, pack(5'd10, 5'd20, 5'd30, 5'd1, 5'd2, 5'd3));
      check("busy_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    send(5'd4, 1'b0);
    send(5'd11, 1'b0);
    send(5'd7, 1'b0);
    send(5'd0, 1'b0);
    send(5'd2, 1'b0);
    @(negedge clk);
    check("busy_next_sort_in", sort_in, pack(5'h1F, 5'd4, 5'd11, 5'd7, 5'd0, 5'd2));
    wait_idle();

    // Reset after three loaded samples.
    send(5'h08, 1'b0);
    send(5'h15, 1'b0);
    send(5'h03, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_load");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(pack(5'h03, 5'h05, 5'h08, 5'h13, 5'h14, 5'h15));
    send_frame(pack(5'h08, 5'h15, 5'h03, 5'h14, 5'h13, 5'h05), 1'b0);
    wait_idle();

    // Reset during DRAIN; the undrained frame is discarded.
    out_ready = 1'b0;
    send_frame(pack(5'h08, 5'h15, 5'h03, 5'h14, 5'h13, 5'h05), 1'b0);
    wait_out_valid();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_drain");
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(pack(5'h03, 5'h05, 5'h08, 5'h13, 5'h14, 5'h15));
    send_frame(pack(5'h08, 5'h15, 5'h03, 5'h14, 5'h13, 5'h05), 1'b0);
    wait_idle();

    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
